// File: rtl/spi_cmd_sequencer.sv
// Flash-style command front-end for the SPI master engine.
// Pushes the header and write payload into the TX FIFO, starts the engine, and streams read bytes back.
module spi_cmd_sequencer #(
    parameter int DATA         = 8,
    parameter int MAX_BYTES    = 256,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_op,
    input  logic [7:0]      req_cmd,
    input  logic [15:0]     req_addr,
    input  logic [11:0]     req_nbytes,
    input  logic [DATA-1:0] pl_data,
    input  logic            pl_valid,
    output logic            pl_ready,
    output logic [DATA-1:0] tx_wdata,
    output logic            tx_wr,
    input  logic            tx_full,
    output logic [15:0]     spi_len,
    output logic            spi_op,
    output logic            spi_work,
    input  logic            spi_busy,
    input  logic [DATA-1:0] rx_rdata,
    output logic            rx_rd,
    input  logic            rx_empty,
    output logic [DATA-1:0] rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic            done,
    output logic            error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PL,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    localparam logic [11:0] MAX_N    = 12'(MAX_BYTES);
    // Error becomes visible one cycle after the decision, so the counter stops two short.
    localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 2);

    state_t          state_q, state_d;
    logic            op_q, op_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [15:0]     addr_q, addr_d;
    logic [11:0]     nbytes_q, nbytes_d;
    logic [11:0]     rem_q, rem_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [15:0]     spi_len_q, spi_len_d;
    logic            spi_op_q, spi_op_d;
    logic [DATA-1:0] rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [7:0]      hdr_byte;
    logic            out_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            nbytes_q   <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            spi_len_q  <= '0;
            spi_op_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            nbytes_q   <= nbytes_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            spi_len_q  <= spi_len_d;
            spi_op_q   <= spi_op_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        nbytes_d   = nbytes_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        spi_len_d  = spi_len_q;
        spi_op_d   = spi_op_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        req_ready  = 1'b0;
        pl_ready   = 1'b0;
        tx_wr      = 1'b0;
        tx_wdata   = '0;
        spi_work   = 1'b0;
        rx_rd      = 1'b0;
        out_free   = 1'b0;

        case (idx_q)
            2'd0:    hdr_byte = cmd_q;
            2'd1:    hdr_byte = addr_q[15:8];
            default: hdr_byte = addr_q[7:0];
        endcase

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d     = req_op;
                    cmd_d    = req_cmd;
                    addr_d   = req_addr;
                    nbytes_d = req_nbytes;
                    if (req_nbytes > MAX_N) begin
                        error_d = 1'b1;
                    end else begin
                        spi_len_d = (16'(req_nbytes) + 16'd3) << 3;
                        spi_op_d  = req_op;
                        idx_d     = 2'd0;
                        state_d   = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (!tx_full) begin
                    tx_wr    = 1'b1;
                    tx_wdata = DATA'(hdr_byte);
                    if (idx_q == 2'd2) begin
                        if (op_q && nbytes_q != 12'd0) begin
                            rem_d   = nbytes_q;
                            state_d = S_PL;
                        end else begin
                            state_d = S_START;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_PL: begin
                pl_ready = !tx_full;
                if (pl_valid && !tx_full) begin
                    tx_wr    = 1'b1;
                    tx_wdata = pl_data;
                    rem_d    = rem_q - 12'd1;
                    if (rem_q == 12'd1) state_d = S_START;
                end
            end
            S_START: begin
                spi_work = 1'b1;
                rem_d    = nbytes_q;
                tmo_d    = '0;
                state_d  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (spi_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_WAIT_LO: begin
                if (op_q) begin
                    if (!spi_busy) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    // The output register can take a new byte if empty or being accepted now.
                    out_free = !rd_valid_q || rd_ready;
                    if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
                    if (!rx_empty && out_free && rem_q != 12'd0) begin
                        rx_rd      = 1'b1;
                        rd_data_d  = rx_rdata;
                        rd_valid_d = 1'b1;
                        rem_d      = rem_q - 12'd1;
                    end else if (!spi_busy && rem_q == 12'd0 && out_free) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign spi_len  = spi_len_q;
    assign spi_op   = spi_op_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: vector table of requests plus a reset-mid-read sequence.
module tb_spi_cmd_sequencer;

  localparam int DATA = 8;
  localparam int BUSY_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_op;
  logic [7:0] req_cmd;
  logic [15:0] req_addr;
  logic [11:0] req_nbytes;
  logic [DATA-1:0] pl_data;
  logic pl_valid, pl_ready;
  logic [DATA-1:0] tx_wdata;
  logic tx_wr, tx_full;
  logic [15:0] spi_len;
  logic spi_op, spi_work, spi_busy;
  logic [DATA-1:0] rx_rdata;
  logic rx_rd, rx_empty;
  logic [DATA-1:0] rd_data;
  logic rd_valid, rd_ready, done, error;

  spi_cmd_sequencer #(.DATA(DATA), .MAX_BYTES(256), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_nbytes(req_nbytes),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full),
    .spi_len(spi_len), .spi_op(spi_op), .spi_work(spi_work), .spi_busy(spi_busy),
    .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .error(error)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [11:0] nbytes;
    logic [31:0] data;     // payload (write) or RX bytes (read), first byte in [31:24]
    logic [15:0] exp_len;
    logic        exp_err;
    int          stall_len;
    logic        dead;
  } vec_t;

  vec_t vecs[8];

  int tests = 0;
  int fails = 0;

  logic [7:0] tx_log[$];
  logic [7:0] rd_log[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    logic [31:0] t;
    t = d << (8 * i);
    return t[31:24];
  endfunction

  // scoreboard compare
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_op = 0; req_cmd = 0; req_addr = 0; req_nbytes = 0;
    pl_data = 0; pl_valid = 0; tx_full = 0; spi_busy = 0;
    rx_rdata = 0; rx_empty = 1; rd_ready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_pl_ready"}, pl_ready, 0);
    check({tag, "_tx_wr"}, tx_wr, 0);
    check({tag, "_tx_wdata"}, tx_wdata, 0);
    check({tag, "_spi_work"}, spi_work, 0);
    check({tag, "_spi_len"}, spi_len, 0);
    check({tag, "_spi_op"}, spi_op, 0);
    check({tag, "_rx_rd"}, rx_rd, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // driver: one request, with bench-side engine and RX FIFO model, cycle by cycle
  task automatic run_txn(input int id, input vec_t v, input bit stop_rdv, output bit stopped);
    int w_cyc, d_cyc, e_cyc, last_acc, pidx, works, k;
    bit got_done, got_err, seen_work, finished;
    logic [15:0] len_at_work;
    logic op_at_work;
    string p;
    p = $sformatf("v%0d", id);
    tx_log.delete(); rd_log.delete(); rx_q.delete(); exp_q.delete();
    w_cyc = 0; d_cyc = 0; e_cyc = 0; last_acc = 0; pidx = 0; works = 0;
    got_done = 0; got_err = 0; seen_work = 0; finished = 0; stopped = 0;
    len_at_work = 0; op_at_work = 0;
    for (int c = 0; c < 120 && !finished; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0);
      req_op = v.op; req_cmd = v.cmd; req_addr = v.addr; req_nbytes = v.nbytes;
      tx_full = (c >= 1 && c <= v.stall_len);
      pl_valid = v.op && (pidx < int'(v.nbytes)) && (pidx < 4);
      pl_data = pl_valid ? byte_of(v.data, pidx) : 8'h00;
      k = c - w_cyc;
      spi_busy = seen_work && !v.dead && k >= 2 && k <= 7;
      if (seen_work && !v.op && k >= 3 && k < 3 + int'(v.nbytes)) rx_q.push_back(byte_of(v.data, k - 3));
      rx_empty = (rx_q.size() == 0);
      rx_rdata = rx_empty ? 8'h00 : rx_q[0];
      rd_ready = stop_rdv ? 1'b0 : ((c % 2) == 1);
      @(negedge clk);
      if (tx_wr && tx_full) check({p, "_wr_while_full"}, tx_wr, 0);
      if (rx_rd && rx_empty) check({p, "_rd_while_empty"}, rx_rd, 0);
      if (done && error) check({p, "_done_and_error"}, done & error, 0);
      if (tx_wr) tx_log.push_back(tx_wdata);
      if (pl_valid && pl_ready) pidx++;
      if (rx_rd && !rx_empty) void'(rx_q.pop_front());
      if (rd_valid && rd_ready) begin rd_log.push_back(rd_data); last_acc = c; end
      if (spi_work) begin
        works++;
        if (!seen_work) begin
          seen_work = 1; w_cyc = c; len_at_work = spi_len; op_at_work = spi_op;
        end
      end
      if (done) begin got_done = 1; d_cyc = c; finished = 1; end
      if (error) begin got_err = 1; e_cyc = c; finished = 1; end
      if (stop_rdv && rd_valid) begin stopped = 1; finished = 1; end
    end
    if (!finished) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no done/error within 120 cycles", p);
    end
    idle_inputs();
    if (stopped) return;

    check({p, "_error"}, got_err, v.exp_err);
    check({p, "_done"}, got_done, !v.exp_err);
    check({p, "_req_ready"}, req_ready, 1);
    if (v.exp_err && !v.dead) begin
      check({p, "_err_latency"}, e_cyc, 1);
      check({p, "_work_cnt"}, works, 0);
      check({p, "_tx_cnt"}, tx_log.size(), 0);
    end else begin
      check({p, "_work_cnt"}, works, 1);
      check({p, "_spi_len"}, len_at_work, v.exp_len);
      check({p, "_spi_op"}, op_at_work, v.op);
      exp_q.push_back(v.cmd);
      exp_q.push_back(v.addr[15:8]);
      exp_q.push_back(v.addr[7:0]);
      if (v.op) for (int i = 0; i < int'(v.nbytes); i++) exp_q.push_back(byte_of(v.data, i));
      check({p, "_tx_cnt"}, tx_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
        check($sformatf("%s_tx%0d", p, i), tx_log[i], exp_q[i]);
      check({p, "_pl_cnt"}, pidx, v.op ? int'(v.nbytes) : 0);
      if (v.dead) begin
        check({p, "_tmo_delay"}, e_cyc - w_cyc, BUSY_TIMEOUT);
      end else if (v.op || v.nbytes == 0) begin
        check({p, "_done_delay"}, d_cyc - w_cyc, 9);
      end else begin
        check({p, "_rd_cnt"}, rd_log.size(), v.nbytes);
        for (int i = 0; i < int'(v.nbytes) && i < rd_log.size(); i++)
          check($sformatf("%s_rd%0d", p, i), rd_log[i], byte_of(v.data, i));
        check({p, "_done_after_acc"}, d_cyc > last_acc, 1);
      end
    end
  endtask

  initial begin
    bit stopped;
    //          op    cmd    addr      n      data          len    err  stall dead
    vecs[0] = '{1'b1, 8'h02, 16'h1234, 12'd2,   32'hAA550000, 16'd40, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b0, 8'h03, 16'h0010, 12'd3,   32'h11223300, 16'd48, 1'b0, 0, 1'b0};
    vecs[2] = '{1'b0, 8'h05, 16'hBEEF, 12'd0,   32'h00000000, 16'd24, 1'b0, 5, 1'b0};
    vecs[3] = '{1'b0, 8'h03, 16'h0000, 12'd300, 32'h00000000, 16'd0,  1'b1, 0, 1'b0};
    vecs[4] = '{1'b1, 8'h02, 16'h0001, 12'd1,   32'h5A000000, 16'd32, 1'b1, 0, 1'b1};
    vecs[5] = '{1'b1, 8'h06, 16'h0000, 12'd0,   32'h00000000, 16'd24, 1'b0, 0, 1'b0};
    vecs[6] = '{1'b0, 8'h0B, 16'hFFFF, 12'd4,   32'hDEADBEEF, 16'd56, 1'b0, 0, 1'b0};
    vecs[7] = '{1'b1, 8'h02, 16'h0000, 12'd257, 32'h00000000, 16'd0,  1'b1, 0, 1'b0};

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i], 1'b0, stopped);

    // reset while a read byte is waiting on rd_ready
    run_txn(10, vecs[1], 1'b1, stopped);
    check("midrd_reached_rd_valid", stopped, 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrd");
    rx_q.delete();
    @(posedge clk); #3 rst = 1'b0;
    run_txn(11, vecs[1], 1'b0, stopped);
    run_txn(12, vecs[0], 1'b0, stopped);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
